// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared types and sizing helpers for the UART receive deserializer.
//   - rxState_t : receive FSM state encoding (also exported for debug)
//   - DEF_*     : default build parameters (4 clk/tick, 16 ticks/bit, 8 bits)
//   - cnt_w()   : width of a counter that must hold values 0..n-1
// ----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rxState_t;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    // Never returns 0 so that a degenerate divider still yields a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_PRESC_W  = cnt_w(DEF_CLK_DIV);
    localparam int DEF_OS_W     = cnt_w(DEF_OVERSAMPLE);
    localparam int DEF_BITCNT_W = cnt_w(DEF_DATA_BITS + 1);

endpackage

// File: rtl/rx_baud_tick.sv
// ----------------------------------------------------------------------------
// rx_baud_tick
//   Prescaler plus oversample counter that locates bit centres.
//   Ports:
//     clk, arstn   : clock, async active-low reset
//     clr_i        : restart both counters (asserted on start-edge detect)
//     startBit_i   : 1 while the start bit is being timed (half-bit target)
//     tick_o       : 1 on the last prescaler cycle of each oversample tick
//     midBit_o     : oversample counter sits at the centre position; the
//                    sample point is tick_o && midBit_o
// ----------------------------------------------------------------------------
module rx_baud_tick
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clk,
    input  logic arstn,
    input  logic clr_i,
    input  logic startBit_i,
    output logic tick_o,
    output logic midBit_o
);

    localparam int PW = cnt_w(CLK_DIV);
    localparam int OW = cnt_w(OVERSAMPLE);

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [OW-1:0] HALF_MAX  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] FULL_MAX  = OW'(OVERSAMPLE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [OW-1:0] os_q, os_d;
    logic [OW-1:0] target;
    logic          sample;

    always_comb begin
        target   = startBit_i ? HALF_MAX : FULL_MAX;
        tick_o   = (presc_q == PRESC_MAX);
        midBit_o = (os_q == target);
        sample   = tick_o & midBit_o;

        presc_d = tick_o ? '0 : presc_q + PW'(1);

        // Wrapping at the sample point makes every later bit a full
        // OVERSAMPLE ticks after the previous centre.
        os_d = os_q;
        if (sample) begin
            os_d = '0;
        end else if (tick_o) begin
            os_d = os_q + OW'(1);
        end

        if (clr_i) begin
            presc_d = '0;
            os_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            presc_q <= '0;
            os_q    <= '0;
        end else begin
            presc_q <= presc_d;
            os_q    <= os_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
//   UART receive deserializer for 8N1 / 8E1 / 8O1 frames. Feeds the status /
//   RX buffer block with a byte plus single-cycle move/error strobes.
//   Ports:
//     clk, arstn  : clock, async active-low reset
//     rxd         : asynchronous serial line, idle high
//     parEn       : parity bit expected after data (latched at start edge)
//     parOdd      : 1 = odd parity, 0 = even (latched at start edge)
//     rxDat       : last received byte, held until the next frame completes
//     rxMvDatEn   : 1-cycle pulse, frame complete and rxDat valid
//     setPErr     : parity error, meaningful only with rxMvDatEn
//     setFErr     : framing error (stop bit low), only with rxMvDatEn
//     rxBusy      : high in every state except IDLE
//     dbgState    : current FSM state, for observation only
// ----------------------------------------------------------------------------
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 rxd,
    input  logic                 parEn,
    input  logic                 parOdd,
    output logic [DATA_BITS-1:0] rxDat,
    output logic                 rxMvDatEn,
    output logic                 setPErr,
    output logic                 setFErr,
    output logic                 rxBusy,
    output rxState_t             dbgState
);

    localparam int                BW       = cnt_w(DATA_BITS + 1);
    localparam logic [BW-1:0]     LAST_BIT = BW'(DATA_BITS - 1);

    // Synchronizer and edge register reset high so that reset release on an
    // idle line can never look like a falling edge.
    logic sync1_q, rxs_q, rxsD_q;

    rxState_t             state_q, state_d;
    logic [BW-1:0]        bitCnt_q, bitCnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parEn_q, parEn_d;
    logic                 parOdd_q, parOdd_d;
    logic                 pErr_q, pErr_d;
    logic [DATA_BITS-1:0] rxDat_q, rxDat_d;
    logic                 mv_q, mv_d;
    logic                 setPErr_q, setPErr_d;
    logic                 setFErr_q, setFErr_d;

    logic startDet;
    logic clr;
    logic baudTick;
    logic midBit;
    logic sample;

    rx_baud_tick #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk        (clk),
        .arstn      (arstn),
        .clr_i      (clr),
        .startBit_i (state_q == START),
        .tick_o     (baudTick),
        .midBit_o   (midBit)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            rxsD_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            rxs_q   <= sync1_q;
            rxsD_q  <= rxs_q;
        end
    end

    always_comb begin
        // Only a true high->low transition starts a frame, so a held-low
        // break line produces one frame and then stays quiet.
        startDet = rxsD_q & ~rxs_q;
        sample   = baudTick & midBit;

        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        parEn_d   = parEn_q;
        parOdd_d  = parOdd_q;
        pErr_d    = pErr_q;
        rxDat_d   = rxDat_q;
        mv_d      = 1'b0;
        setPErr_d = 1'b0;
        setFErr_d = 1'b0;
        clr       = 1'b0;

        case (state_q)
            IDLE: begin
                if (startDet) begin
                    state_d  = START;
                    clr      = 1'b1;
                    parEn_d  = parEn;
                    parOdd_d = parOdd;
                    pErr_d   = 1'b0;
                end
            end
            START: begin
                if (sample) begin
                    if (rxs_q) begin
                        state_d = IDLE;   // glitch shorter than half a bit
                    end else begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = parEn_q ? PARITY : STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    pErr_d  = rxs_q ^ (^shift_q) ^ parOdd_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Return to IDLE right at the stop centre so a back-to-back
                // start edge is caught without a half-bit wait.
                if (sample) begin
                    rxDat_d   = shift_q;
                    mv_d      = 1'b1;
                    setPErr_d = pErr_q & parEn_q;
                    setFErr_d = ~rxs_q;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            shift_q   <= '0;
            parEn_q   <= 1'b0;
            parOdd_q  <= 1'b0;
            pErr_q    <= 1'b0;
            rxDat_q   <= '0;
            mv_q      <= 1'b0;
            setPErr_q <= 1'b0;
            setFErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            shift_q   <= shift_d;
            parEn_q   <= parEn_d;
            parOdd_q  <= parOdd_d;
            pErr_q    <= pErr_d;
            rxDat_q   <= rxDat_d;
            mv_q      <= mv_d;
            setPErr_q <= setPErr_d;
            setFErr_q <= setFErr_d;
        end
    end

    assign rxDat     = rxDat_q;
    assign rxMvDatEn = mv_q;
    assign setPErr   = setPErr_q;
    assign setFErr   = setFErr_q;
    assign rxBusy    = (state_q != IDLE);
    assign dbgState  = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
`timescale 1ns/1ps
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

    localparam int BIT_CLK = 64;   // CLK_DIV 4 * OVERSAMPLE 16

    logic       clk = 1'b0;
    logic       arstn = 1'b0;
    logic       rxd = 1'b1;
    logic       parEn = 1'b0;
    logic       parOdd = 1'b0;
    logic [7:0] rxDat;
    logic       rxMvDatEn, setPErr, setFErr, rxBusy;
    rxState_t   dbgState;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int last_strobe_cyc = 0;

    // Scoreboard entries: {ferr, perr, data}
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic       prev_mv = 1'b0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_frame #(
        .CLK_DIV    (4),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .rxd       (rxd),
        .parEn     (parEn),
        .parOdd    (parOdd),
        .rxDat     (rxDat),
        .rxMvDatEn (rxMvDatEn),
        .setPErr   (setPErr),
        .setFErr   (setFErr),
        .rxBusy    (rxBusy),
        .dbgState  (dbgState)
    );

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!arstn) begin
            prev_mv = 1'b0;
        end else begin
            if (rxMvDatEn) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_strobe: got dat=%02h perr=%b ferr=%b, required no strobe",
                             rxDat, setPErr, setFErr);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({setFErr, setPErr, rxDat} !== exp_v) begin
                        fails++;
                        $display("FAIL strobe_payload: got ferr=%b perr=%b dat=%02h, required ferr=%b perr=%b dat=%02h",
                                 setFErr, setPErr, rxDat, exp_v[9], exp_v[8], exp_v[7:0]);
                    end
                end
                tests++;
                if (prev_mv !== 1'b0) begin
                    fails++;
                    $display("FAIL strobe_width: rxMvDatEn high in consecutive cycles, required single cycle");
                end
            end else if (setPErr !== 1'b0 || setFErr !== 1'b0) begin
                tests++;
                fails++;
                $display("FAIL flags_without_strobe: got perr=%b ferr=%b, required 0 0", setPErr, setFErr);
            end
            prev_mv = rxMvDatEn;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    // Reference model: expected flags from the frame's own contents, using the
    // parity configuration presented at the start edge.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                              input logic pbit, input logic stopb, input logic scramble);
        int   ones;
        logic perr;
        ones = $countones(d) + int'(pbit);
        perr = pe && ((ones % 2) != int'(po));
        exp_q.push_back({~stopb, perr, d});
        parEn  = pe;
        parOdd = po;
        drive_bit(1'b0);
        if (scramble) begin
            parEn  = 1'($urandom_range(0, 1));
            parOdd = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pe) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        tests++;
        if ({rxDat, rxMvDatEn, setPErr, setFErr, rxBusy} !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: got dat=%02h mv=%b pe=%b fe=%b busy=%b, required all 0",
                     rxDat, rxMvDatEn, setPErr, setFErr, rxBusy);
        end
        tests++;
        if (dbgState !== IDLE) begin
            fails++;
            $display("FAIL reset_state: got %0d, required IDLE", dbgState);
        end
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (rxBusy !== 1'b0 || strobe_cnt !== 0) begin
            fails++;
            $display("FAIL idle_after_reset: got busy=%b strobes=%0d, required 0 0", rxBusy, strobe_cnt);
        end
    endtask

    task automatic test_8n1();
        int n0, t0, lat;
        n0 = strobe_cnt;
        drive_bit(1'b1);
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        lat = last_strobe_cyc - t0;
        tests++;
        if (strobe_cnt !== n0 + 1) begin
            fails++;
            $display("FAIL 8n1_count: got %0d strobes, required 1", strobe_cnt - n0);
        end
        // Stop centre is 9.5 bits (608 clk) after the edge, plus a few clk
        // of synchronizer/edge detection and the strobe register.
        tests++;
        if (lat < 609 || lat > 614) begin
            fails++;
            $display("FAIL 8n1_latency: got %0d clk, required 609..614", lat);
        end
        tests++;
        if (rxDat !== 8'hA5 || rxBusy !== 1'b0) begin
            fails++;
            $display("FAIL 8n1_hold: got dat=%02h busy=%b, required A5 0", rxDat, rxBusy);
        end
    endtask

    task automatic test_parity();
        int n0;
        n0 = strobe_cnt;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);   // even, wrong parity
        drive_bit(1'b1);
        send_frame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);   // even, correct
        drive_bit(1'b1);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);   // odd, correct
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0 + 3 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL parity_count: got %0d strobes pending=%0d, required 3 0",
                     strobe_cnt - n0, exp_q.size());
        end
    endtask

    task automatic test_framing();
        int n0;
        n0 = strobe_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;                                         // break: held low
        repeat (2000) @(posedge clk);
        #1;
        tests++;
        if (strobe_cnt !== n0 + 1 || rxBusy !== 1'b0) begin
            fails++;
            $display("FAIL break_quiet: got %0d strobes busy=%b, required 1 0", strobe_cnt - n0, rxBusy);
        end
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0 + 2 || rxDat !== 8'h11 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL after_break: got %0d strobes dat=%02h, required 2 11", strobe_cnt - n0, rxDat);
        end
    endtask

    task automatic test_glitch();
        int n0;
        n0 = strobe_cnt;
        rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (rxBusy !== 1'b1) begin
            fails++;
            $display("FAIL glitch_busy: got busy=%b, required 1", rxBusy);
        end
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (rxBusy !== 1'b0 || dbgState !== IDLE) begin
            fails++;
            $display("FAIL glitch_abort: got busy=%b state=%0d, required 0 IDLE", rxBusy, dbgState);
        end
        repeat (700) @(posedge clk);
        #1;
        tests++;
        if (strobe_cnt !== n0) begin
            fails++;
            $display("FAIL glitch_strobe: got %0d strobes, required 0", strobe_cnt - n0);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        n0 = strobe_cnt;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0 + 2 || rxDat !== 8'hFF || exp_q.size() != 0) begin
            fails++;
            $display("FAIL back_to_back: got %0d strobes dat=%02h, required 2 FF", strobe_cnt - n0, rxDat);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n0;
        n0 = strobe_cnt;
        parEn = 1'b0;
        drive_bit(1'b0);                 // start bit of 0x3C
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rxd = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (rxBusy !== 1'b1 || dbgState !== DATA) begin
            fails++;
            $display("FAIL mid_frame_state: got busy=%b state=%0d, required 1 DATA", rxBusy, dbgState);
        end
        arstn = 1'b0;
        #1;
        tests++;
        if ({rxDat, rxMvDatEn, setPErr, setFErr, rxBusy} !== 12'h000 || dbgState !== IDLE) begin
            fails++;
            $display("FAIL async_reset: got dat=%02h mv=%b busy=%b state=%0d, required all 0 IDLE",
                     rxDat, rxMvDatEn, rxBusy, dbgState);
        end
        repeat (5) @(posedge clk);
        #1 arstn = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0) begin
            fails++;
            $display("FAIL reset_no_strobe: got %0d strobes, required 0", strobe_cnt - n0);
        end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0 + 1 || rxDat !== 8'hC3) begin
            fails++;
            $display("FAIL after_reset: got %0d strobes dat=%02h, required 1 C3", strobe_cnt - n0, rxDat);
        end
    endtask

    task automatic test_random();
        int   n0;
        logic [7:0] d;
        logic pe, po, pb;
        n0 = strobe_cnt;
        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            send_frame(d, pe, po, pb, 1'b1, 1'b1);
            rxd = 1'b1;
            repeat ($urandom_range(0, 30)) @(posedge clk);
            #1;
        end
        drive_bit(1'b1);
        tests++;
        if (strobe_cnt !== n0 + 8 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL random_count: got %0d strobes pending=%0d, required 8 0",
                     strobe_cnt - n0, exp_q.size());
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL final_queue: got %0d frames undelivered, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
